// File: rtl/interrupt_sequencer_if.sv
// ---------------------------------------------------------------------------
// interrupt_sequencer_if
//
// Purpose : Stack-memory side of the interrupt sequencer. The sequencer
//           drives push/pop requests, the write-source selector and the
//           16-bit word to be pushed, and receives the word being popped.
//
// Signals :
//   mem_push                 - stack push request (one word per cycle)
//   mem_pop                  - stack pop request (one word per cycle)
//   memory_write_src_select  - 00 normal, 01 PC[31:16], 10 PC[15:0],
//                              11 {13'b0, CCR}
//   push_data                - word selected by memory_write_src_select
//                              from the saved PC/CCR (0 when not pushing)
//   pop_data                 - stack read data, valid while mem_pop is high
//
// Modports:
//   master - the sequencer
//   slave  - the stack memory / memory stage
// ---------------------------------------------------------------------------
interface interrupt_sequencer_if;
    logic        mem_push;
    logic        mem_pop;
    logic [1:0]  memory_write_src_select;
    logic [15:0] push_data;
    logic [15:0] pop_data;

    modport master (
        output mem_push,
        output mem_pop,
        output memory_write_src_select,
        output push_data,
        input  pop_data
    );

    modport slave (
        input  mem_push,
        input  mem_pop,
        input  memory_write_src_select,
        input  push_data,
        output pop_data
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// ---------------------------------------------------------------------------
// interrupt_sequencer
//
// Purpose : Sequences interrupt entry and return-from-interrupt for a
//           pipelined CPU with a 16-bit stack.
//           Entry : push PC[31:16], PC[15:0], CCR, then jump to INT_VECTOR.
//           RTI   : pop CCR, PC[15:0], PC[31:16], then reload PC and CCR.
//           Every non-IDLE state squashes the front of the pipeline, and a
//           memory stall freezes the sequencer completely.
//
// Parameters:
//   INT_VECTOR - PC value loaded on interrupt entry
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   int_req        in   level interrupt request
//   rti_dec        in   RTI decoded in execute this cycle
//   stall_in       in   memory busy; freezes the sequencer
//   PC             in   PC of the instruction currently in execute
//   ccr_in         in   current condition code register
//   mem            --   stack bus (master modport), see interrupt_sequencer_if
//   flush          out  squash fetch/decode/execute
//   pc_load        out  load pc_load_value into PC
//   pc_load_value  out  target PC
//   ccr_restore    out  load ccr_out into CCR
//   ccr_out        out  restored flags
//   busy           out  sequencer not IDLE
// ---------------------------------------------------------------------------
module interrupt_sequencer #(
    parameter logic [31:0] INT_VECTOR = 32'h0000_0020
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          int_req,
    input  logic                          rti_dec,
    input  logic                          stall_in,
    input  logic [31:0]                   PC,
    input  logic [2:0]                    ccr_in,
    interrupt_sequencer_if.master         mem,
    output logic                          flush,
    output logic                          pc_load,
    output logic [31:0]                   pc_load_value,
    output logic                          ccr_restore,
    output logic [2:0]                    ccr_out,
    output logic                          busy
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_PUSH_HI  = 4'd1,
        S_PUSH_LO  = 4'd2,
        S_PUSH_CCR = 4'd3,
        S_JUMP     = 4'd4,
        S_POP_CCR  = 4'd5,
        S_POP_LO   = 4'd6,
        S_POP_HI   = 4'd7,
        S_RESUME   = 4'd8
    } state_t;

    localparam logic [1:0] SRC_NORMAL = 2'b00;
    localparam logic [1:0] SRC_PC_HI  = 2'b01;
    localparam logic [1:0] SRC_PC_LO  = 2'b10;
    localparam logic [1:0] SRC_CCR    = 2'b11;

    state_t      state_q,    state_d;
    // Context captured on interrupt entry; pushed over the next three cycles.
    logic [31:0] save_pc_q,  save_pc_d;
    logic [2:0]  save_ccr_q, save_ccr_d;
    // Context rebuilt from the stack during RTI.
    logic [31:0] ret_pc_q,   ret_pc_d;
    logic [2:0]  ret_ccr_q,  ret_ccr_d;

    logic        start_entry;
    logic        start_rti;

    // IDLE departure decision. Interrupts win over RTI: the RTI's own PC is
    // saved, so the RTI re-executes once the handler returns.
    assign start_entry = !reset && !stall_in && int_req;
    assign start_rti   = !reset && !stall_in && !int_req && rti_dec;

    // -----------------------------------------------------------------------
    // State and context registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            save_pc_q  <= '0;
            save_ccr_q <= '0;
            ret_pc_q   <= '0;
            ret_ccr_q  <= '0;
        end else begin
            state_q    <= state_d;
            save_pc_q  <= save_pc_d;
            save_ccr_q <= save_ccr_d;
            ret_pc_q   <= ret_pc_d;
            ret_ccr_q  <= ret_ccr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and capture logic. A stall leaves every _d equal to its _q,
    // so state and all captured context freeze together.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        save_pc_d  = save_pc_q;
        save_ccr_d = save_ccr_q;
        ret_pc_d   = ret_pc_q;
        ret_ccr_d  = ret_ccr_q;

        if (!stall_in) begin
            case (state_q)
                S_IDLE: begin
                    if (start_entry) begin
                        save_pc_d  = PC;
                        save_ccr_d = ccr_in;
                        state_d    = S_PUSH_HI;
                    end else if (start_rti) begin
                        state_d    = S_POP_CCR;
                    end
                end
                S_PUSH_HI:  state_d = S_PUSH_LO;
                S_PUSH_LO:  state_d = S_PUSH_CCR;
                S_PUSH_CCR: state_d = S_JUMP;
                S_JUMP:     state_d = S_IDLE;
                S_POP_CCR: begin
                    ret_ccr_d = mem.pop_data[2:0];
                    state_d   = S_POP_LO;
                end
                S_POP_LO: begin
                    ret_pc_d[15:0] = mem.pop_data;
                    state_d        = S_POP_HI;
                end
                S_POP_HI: begin
                    ret_pc_d[31:16] = mem.pop_data;
                    state_d         = S_RESUME;
                end
                S_RESUME:   state_d = S_IDLE;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output decode. Outputs depend on the held state only (plus the IDLE
    // departure decision), so a stall keeps them steady automatically.
    // -----------------------------------------------------------------------
    always_comb begin
        mem.mem_push                = 1'b0;
        mem.mem_pop                 = 1'b0;
        mem.memory_write_src_select = SRC_NORMAL;
        flush                       = 1'b1;
        pc_load                     = 1'b0;
        ccr_restore                 = 1'b0;

        case (state_q)
            S_IDLE: flush = start_entry || start_rti;
            S_PUSH_HI: begin
                mem.mem_push                = 1'b1;
                mem.memory_write_src_select = SRC_PC_HI;
            end
            S_PUSH_LO: begin
                mem.mem_push                = 1'b1;
                mem.memory_write_src_select = SRC_PC_LO;
            end
            S_PUSH_CCR: begin
                mem.mem_push                = 1'b1;
                mem.memory_write_src_select = SRC_CCR;
            end
            S_JUMP:    pc_load     = 1'b1;
            S_POP_CCR: mem.mem_pop = 1'b1;
            S_POP_LO:  mem.mem_pop = 1'b1;
            S_POP_HI:  mem.mem_pop = 1'b1;
            S_RESUME: begin
                pc_load     = 1'b1;
                ccr_restore = 1'b1;
            end
            default:   flush = 1'b0;
        endcase
    end

    // Word pushed this cycle, taken from the context captured on entry.
    always_comb begin
        case (mem.memory_write_src_select)
            SRC_PC_HI: mem.push_data = save_pc_q[31:16];
            SRC_PC_LO: mem.push_data = save_pc_q[15:0];
            SRC_CCR:   mem.push_data = {13'b0, save_ccr_q};
            default:   mem.push_data = 16'h0000;
        endcase
    end

    // JUMP targets the vector; otherwise show the PC rebuilt from the stack.
    assign pc_load_value = (state_q == S_JUMP) ? INT_VECTOR : ret_pc_q;
    assign ccr_out       = ret_ccr_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_interrupt_sequencer.sv
// ---------------------------------------------------------------------------
// tb_interrupt_sequencer
//
// Directed testbench. Inputs change 1 ns after the rising edge, outputs are
// sampled 1 ns later. Control outputs are packed per cycle as
// {busy, flush, mem_push, mem_pop, select[1:0], pc_load, ccr_restore}.
// ---------------------------------------------------------------------------
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        int_req;
    logic        rti_dec;
    logic        stall_in;
    logic [31:0] PC;
    logic [2:0]  ccr_in;
    logic        flush;
    logic        pc_load;
    logic [31:0] pc_load_value;
    logic        ccr_restore;
    logic [2:0]  ccr_out;
    logic        busy;

    int tests = 0;
    int fails = 0;

    interrupt_sequencer_if mem_if ();

    interrupt_sequencer #(.INT_VECTOR(32'h0000_0020)) dut (
        .clk           (clk),
        .reset         (reset),
        .int_req       (int_req),
        .rti_dec       (rti_dec),
        .stall_in      (stall_in),
        .PC            (PC),
        .ccr_in        (ccr_in),
        .mem           (mem_if),
        .flush         (flush),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .ccr_restore   (ccr_restore),
        .ccr_out       (ccr_out),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ctl();
        return {busy, flush, mem_if.mem_push, mem_if.mem_pop,
                mem_if.memory_write_src_select, pc_load, ccr_restore};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; int_req = 1'b1; rti_dec = 1'b1; stall_in = 1'b0;
        PC = 32'h1234_5678; ccr_in = 3'b111; mem_if.pop_data = 16'hFFFF;
        next_cycle();
        next_cycle();
        #1;
        tests++;
        if (ctl() !== 8'h00) begin
            fails++; $display("FAIL reset_held_ctl got %h exp %h", ctl(), 8'h00);
        end
        next_cycle();
        reset = 1'b0; int_req = 1'b0; rti_dec = 1'b0;
        #1;
        tests++;
        if ({ctl(), pc_load_value, ccr_out, mem_if.push_data} !== {8'h00, 32'h0, 3'b000, 16'h0}) begin
            fails++;
            $display("FAIL reset_state got ctl=%h pcv=%h ccr=%b push=%h exp all zero",
                     ctl(), pc_load_value, ccr_out, mem_if.push_data);
        end
        $display("[TB] reset: ctl=%h pcv=%h ccr=%b", ctl(), pc_load_value, ccr_out);
        next_cycle();
    endtask

    task automatic test_entry();
        logic [7:0]  exp_ctl  [6];
        logic [15:0] exp_data [6];
        exp_ctl  = '{8'h40, 8'hE4, 8'hE8, 8'hEC, 8'hC2, 8'h00};
        exp_data = '{16'h0, 16'h0001, 16'h2345, 16'h0005, 16'h0, 16'h0};
        for (int i = 0; i < 6; i++) begin
            int_req = (i == 0);
            // PC/CCR change after entry: pushes must use the captured copy.
            PC      = (i == 0) ? 32'h0001_2345 : 32'hDEAD_BEEF;
            ccr_in  = (i == 0) ? 3'b101 : 3'b010;
            #1;
            tests++;
            if (ctl() !== exp_ctl[i]) begin
                fails++; $display("FAIL entry_ctl[%0d] got %h exp %h", i, ctl(), exp_ctl[i]);
            end
            if (i >= 1 && i <= 3) begin
                tests++;
                if (mem_if.push_data !== exp_data[i]) begin
                    fails++; $display("FAIL entry_push[%0d] got %h exp %h", i, mem_if.push_data, exp_data[i]);
                end
            end
            if (i == 4) begin
                tests++;
                if (pc_load_value !== 32'h0000_0020) begin
                    fails++; $display("FAIL entry_vector got %h exp %h", pc_load_value, 32'h0000_0020);
                end
            end
            $display("[TB] entry cycle %0d: ctl=%h push=%h pcv=%h", i, ctl(), mem_if.push_data, pc_load_value);
            next_cycle();
        end
    endtask

    task automatic test_rti();
        logic [7:0]  exp_ctl [6];
        logic [15:0] pops    [6];
        exp_ctl = '{8'h40, 8'hD0, 8'hD0, 8'hD0, 8'hC3, 8'h00};
        pops    = '{16'hAAAA, 16'h0005, 16'h2345, 16'h0001, 16'hBBBB, 16'hCCCC};
        for (int i = 0; i < 6; i++) begin
            rti_dec = (i == 0);
            mem_if.pop_data = pops[i];
            #1;
            tests++;
            if (ctl() !== exp_ctl[i]) begin
                fails++; $display("FAIL rti_ctl[%0d] got %h exp %h", i, ctl(), exp_ctl[i]);
            end
            if (i == 4) begin
                tests++;
                if ({pc_load_value, ccr_out} !== {32'h0001_2345, 3'b101}) begin
                    fails++;
                    $display("FAIL rti_restore got pcv=%h ccr=%b exp pcv=%h ccr=%b",
                             pc_load_value, ccr_out, 32'h0001_2345, 3'b101);
                end
            end
            $display("[TB] rti cycle %0d: ctl=%h pcv=%h ccr=%b", i, ctl(), pc_load_value, ccr_out);
            next_cycle();
        end
    endtask

    task automatic test_priority();
        logic [7:0]  exp_ctl  [6];
        logic [15:0] exp_data [6];
        logic        pop_seen;
        exp_ctl  = '{8'h40, 8'hE4, 8'hE8, 8'hEC, 8'hC2, 8'h00};
        exp_data = '{16'h0, 16'h5555, 16'h1111, 16'h0003, 16'h0, 16'h0};
        pop_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            int_req = (i == 0);
            rti_dec = (i <= 4);   // held high while busy: must be ignored
            PC      = 32'h5555_1111;
            ccr_in  = 3'b011;
            #1;
            pop_seen = pop_seen | mem_if.mem_pop;
            tests++;
            if (ctl() !== exp_ctl[i]) begin
                fails++; $display("FAIL prio_ctl[%0d] got %h exp %h", i, ctl(), exp_ctl[i]);
            end
            if (i >= 1 && i <= 3) begin
                tests++;
                if (mem_if.push_data !== exp_data[i]) begin
                    fails++; $display("FAIL prio_push[%0d] got %h exp %h", i, mem_if.push_data, exp_data[i]);
                end
            end
            $display("[TB] prio cycle %0d: ctl=%h push=%h", i, ctl(), mem_if.push_data);
            next_cycle();
        end
        tests++;
        if (pop_seen !== 1'b0) begin
            fails++; $display("FAIL prio_no_pop got %b exp %b", pop_seen, 1'b0);
        end
    endtask

    task automatic test_stall();
        logic [7:0]  exp_ctl  [9];
        logic [15:0] exp_data [9];
        logic [15:0] last;
        int          push_cycles;
        int          distinct;
        exp_ctl  = '{8'h40, 8'hE4, 8'hE8, 8'hE8, 8'hE8, 8'hE8, 8'hEC, 8'hC2, 8'h00};
        exp_data = '{16'h0, 16'hABCD, 16'h0123, 16'h0123, 16'h0123, 16'h0123, 16'h0006, 16'h0, 16'h0};
        push_cycles = 0; distinct = 0; last = 16'hxxxx;
        for (int i = 0; i < 9; i++) begin
            int_req  = (i == 0);
            stall_in = (i >= 2 && i <= 4);
            PC       = (i == 0) ? 32'hABCD_0123 : 32'h0;
            ccr_in   = (i == 0) ? 3'b110 : 3'b000;
            #1;
            if (mem_if.mem_push === 1'b1) begin
                push_cycles++;
                if (mem_if.push_data !== last) distinct++;
                last = mem_if.push_data;
            end
            tests++;
            if ({ctl(), mem_if.push_data} !== {exp_ctl[i], exp_data[i]}) begin
                fails++;
                $display("FAIL stall_cycle[%0d] got ctl=%h push=%h exp ctl=%h push=%h",
                         i, ctl(), mem_if.push_data, exp_ctl[i], exp_data[i]);
            end
            $display("[TB] stall cycle %0d: stall=%b ctl=%h push=%h", i, stall_in, ctl(), mem_if.push_data);
            next_cycle();
        end
        stall_in = 1'b0;
        tests++;
        if ({push_cycles, distinct} !== {32'd6, 32'd3}) begin
            fails++;
            $display("FAIL stall_push_count got cycles=%0d distinct=%0d exp cycles=6 distinct=3",
                     push_cycles, distinct);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_ctl [7];
        exp_ctl = '{8'h40, 8'hD0, 8'hD0, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 7; i++) begin
            rti_dec = (i == 0);
            reset   = (i == 2);   // asserted while in POP_LO
            mem_if.pop_data = (i == 1) ? 16'h0007 : 16'h2345;
            #1;
            tests++;
            if (ctl() !== exp_ctl[i]) begin
                fails++; $display("FAIL rstmid_ctl[%0d] got %h exp %h", i, ctl(), exp_ctl[i]);
            end
            if (i == 3) begin
                tests++;
                if ({pc_load_value, ccr_out} !== {32'h0, 3'b000}) begin
                    fails++;
                    $display("FAIL rstmid_regs got pcv=%h ccr=%b exp pcv=%h ccr=%b",
                             pc_load_value, ccr_out, 32'h0, 3'b000);
                end
            end
            $display("[TB] rstmid cycle %0d: reset=%b ctl=%h pcv=%h", i, reset, ctl(), pc_load_value);
            next_cycle();
        end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_ctl [11];
        int         idle_cycles;
        exp_ctl = '{8'h40, 8'hE4, 8'hE8, 8'hEC, 8'hC2, 8'h40,
                    8'hE4, 8'hE8, 8'hEC, 8'hC2, 8'h00};
        idle_cycles = 0;
        for (int i = 0; i < 11; i++) begin
            int_req = (i <= 5);
            PC      = 32'h0000_4000;
            ccr_in  = 3'b001;
            #1;
            if (i >= 1 && i <= 9 && busy === 1'b0) idle_cycles++;
            tests++;
            if (ctl() !== exp_ctl[i]) begin
                fails++; $display("FAIL b2b_ctl[%0d] got %h exp %h", i, ctl(), exp_ctl[i]);
            end
            $display("[TB] b2b cycle %0d: int_req=%b ctl=%h", i, int_req, ctl());
            next_cycle();
        end
        int_req = 1'b0;
        tests++;
        if (idle_cycles !== 1) begin
            fails++; $display("FAIL b2b_idle_gap got %0d exp %0d", idle_cycles, 1);
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_rti();
        test_priority();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 SHALL have parameter INT_VECTOR, default 32'h0000_0020, PC value loaded on interrupt entry.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port int_req  in  1  level interrupt request.
REQ-005 SHALL have port rti_dec  in  1  RTI decoded in execute this cycle.
REQ-006 SHALL have port stall_in  in  1  memory busy; freezes sequencer.
REQ-007 SHALL have port PC  in  32  PC of instruction currently in execute.
REQ-008 SHALL have port ccr_in  in  3  current condition code register.
REQ-009 SHALL have port pop_data  in  16  stack read data, valid in the cycle mem_pop is high.
REQ-010 SHALL have port mem_push  out  1  stack push request.
REQ-011 SHALL have port mem_pop  out  1  stack pop request.
REQ-012 SHALL have port memory_write_src_select  out  2  00 normal, 01 PC[31:16], 10 PC[15:0], 11 {13'b0,CCR}.
REQ-013 SHALL have port flush  out  1  squash fetch/decode/execute.
REQ-014 SHALL have port pc_load  out  1  load pc_load_value into PC.
REQ-015 SHALL have port pc_load_value  out  32  target PC.
REQ-016 SHALL have port ccr_restore  out  1  load ccr_out into CCR.
REQ-017 SHALL have port ccr_out  out  3  restored flags.
REQ-018 SHALL have port busy  out  1  sequencer not IDLE.

Function
REQ-019 SHALL implement states IDLE, PUSH_HI, PUSH_LO, PUSH_CCR, JUMP, POP_CCR, POP_LO, POP_HI, RESUME.
REQ-020 SHALL, in IDLE with int_req=1, capture PC and ccr_in into internal save registers and go to PUSH_HI.
REQ-021 SHALL, in IDLE with int_req=0 and rti_dec=1, go to POP_CCR.
REQ-022 SHALL give int_req priority over rti_dec when both are high in IDLE; the saved PC is that of the RTI, which re-executes after return.
REQ-023 SHALL, in PUSH_HI/PUSH_LO/PUSH_CCR, assert mem_push with memory_write_src_select 01/10/11 respectively, then advance in that order.
REQ-024 SHALL, in JUMP, assert pc_load with pc_load_value=INT_VECTOR, then return to IDLE.
REQ-025 SHALL, in POP_CCR, assert mem_pop and capture pop_data[2:0] into ccr_out at the clock edge.
REQ-026 SHALL, in POP_LO then POP_HI, assert mem_pop and capture pop_data into pc_load_value[15:0] and [31:16] respectively.
REQ-027 SHALL, in RESUME, assert pc_load and ccr_restore for exactly one cycle, then return to IDLE.
REQ-028 SHALL assert flush in every non-IDLE state and in the IDLE cycle where a transition out of IDLE is taken.
REQ-029 SHALL, while stall_in=1, hold the current state, all captured registers and all outputs unchanged.
REQ-030 SHALL ignore int_req and rti_dec outside IDLE; int_req still high on return to IDLE starts a new entry (level semantics).
REQ-031 SHALL yield entry latency of 4 non-stalled cycles from leaving IDLE to the pc_load cycle, and RTI latency of 4 cycles likewise.
REQ-032 SHALL drive mem_push, mem_pop, pc_load and ccr_restore mutually exclusive and at most one cycle per state visit, excluding stall-extended cycles.
REQ-033 SHALL keep busy=1 exactly when state is not IDLE.

Reset
REQ-034 SHALL, on reset=1 at a clock edge, enter IDLE from any state, including mid-sequence, with no further push or pop issued.
REQ-035 SHALL reset all outputs to 0, memory_write_src_select to 00, and save registers to 0.
REQ-036 SHALL give reset priority over stall_in, int_req and rti_dec.

Verification
REQ-037 SHALL cover: PC=32'h0001_2345, ccr_in=3'b101, int_req pulse -> pushes 16'h0001, 16'h2345, 16'h0005 in three consecutive cycles, then pc_load with 32'h0000_0020.
REQ-038 SHALL cover: rti_dec with pop_data 16'h0005, 16'h2345, 16'h0001 -> RESUME with pc_load_value 32'h0001_2345, ccr_out 3'b101.
REQ-039 SHALL cover: int_req and rti_dec high together in IDLE -> interrupt entry, no mem_pop.
REQ-040 SHALL cover: stall_in high for 3 cycles during PUSH_LO -> mem_push and select 10 held 3 extra cycles, exactly 3 distinct push values total.
REQ-041 SHALL cover: reset asserted in POP_LO -> next cycle IDLE, all outputs 0, no pc_load.
REQ-042 SHALL cover: int_req held high across JUMP -> one IDLE cycle, then a second entry starting at PUSH_HI.
